sdram_frame_reader: RTL and testbench
=====================================

# sdram_frame_reader

Read-side feeder between the SDRAM port arbiter and the VGA output path, all in the SDRAM clock domain. Per frame, it issues sequential SDRAM read commands starting at a frame offset. It accepts the in-order read returns into an internal buffer and streams pixels out to the VGA-domain clock-crossing FIFO. Credit-based flow control caps in-flight reads plus buffered words at buffer depth, so read data is never dropped for lack of space.

## Interface
- FRAME_WORDS, 307200: words per frame (640x480).
- BUF_DEPTH, 64: return buffer depth; power of two, at least 4.
- LOW_WATER, 16: urgency threshold; must be less than BUF_DEPTH.
- clk  in  1: SDRAM controller clock; single clock domain.
- rst  in  1: synchronous, active-high reset.
- start_frame  in  1: one-cycle pulse; begins a frame when in IDLE.
- frame_offset  in  25: base word address; sampled on an accepted start_frame.
- cmd_valid  out  1: read command request to the arbiter.
- cmd_ready  in  1: arbiter accepts the command this cycle.
- cmd_addr  out  25: word address of the request.
- urgent  out  1: asks the arbiter to prioritise this port.
- rd_valid  in  1: read-return strobe from the SDRAM controller.
- rd_addr  in  25: address of the returned word.
- rd_data  in  16: returned word.
- out_valid  out  1: pixel word available.
- out_ready  in  1: downstream accepts the word.
- out_data  out  16: pixel word.
- out_last  out  1: marks the final word of the frame.
- busy  out  1: high whenever the FSM is not in IDLE.
- err  out  1: sticky error flag; cleared only by rst.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE to FETCH on start_frame. This latches frame_offset and clears issued, returned and popped counters.
  - FETCH to DRAIN on the cycle the command with issued == FRAME_WORDS-1 is accepted.
  - DRAIN to IDLE on the cycle the word with popped == FRAME_WORDS-1 is popped (handshake with out_last=1).
- start_frame outside IDLE is ignored; no state changes.
- Credits: inflight = issued - returned; buffered = FIFO occupancy.
  - cmd_valid = (state==FETCH) && (inflight + buffered < BUF_DEPTH).
  - A command is issued when cmd_valid && cmd_ready; issued increments.
- cmd_addr = frame_offset + issued, computed modulo 2^25 so the address wraps past 0x1FFFFFF.
- urgent = (state==FETCH) && (inflight + buffered < LOW_WATER).
- Read returns:
  - rd_valid with inflight > 0: rd_data is written to the FIFO and returned increments.
  - rd_valid with inflight == 0 (spurious): the word is dropped and err is set.
- out_last = out_valid && (popped == FRAME_WORDS-1).
- Widths: frame counters are clog2(FRAME_WORDS+1) bits. The credit sum is clog2(BUF_DEPTH)+1 bits.
- Simultaneous issue, return and pop in one cycle: all counters update in that same cycle. The credit check uses pre-update values (conservative).

## Timing
- cmd_valid and cmd_addr are registered. After acceptance, the next address is presented on the following cycle.
- Back-to-back issue at 1 command/cycle is supported while credit remains.
- rd_valid to out_valid latency is 1 cycle when the FIFO was empty.
- Pop throughput is 1 word/cycle.
- out_valid and out_data hold until out_ready is seen.
- Reset values: state IDLE; cmd_valid, urgent, out_valid, out_last, busy and err all 0; cmd_addr and out_data 0; FIFO emptied.
- Reset mid-frame aborts immediately. Returns for reads issued before reset that arrive after it count as spurious and set err; the bench must quiesce the controller first.

## Configuration
- SDRAM_FRAME_READER_ADDR_CHECK_EN
  - Defined: each return's rd_addr is compared with frame_offset + returned. On mismatch the word is still stored and counted, err is set, and the FSM continues.
  - Undefined: rd_addr is ignored; no comparator or address register is built.

## Structure
- Shared package sdram_pkg: SDRAM_ADDR_W=25, SDRAM_DATA_W=16, FSM state enum fr_state_t.
- One sub-module: sync_fifo (parameterised width/depth, first-word-fall-through, occupancy output). The FSM, counters and credit logic live in the top level.

## Test plan
- FRAME_WORDS=8, offset 0x100, cmd_ready=1, returns 2 cycles after each issue, out_ready=1 -> addresses 0x100..0x107 issued in order; 8 words out; out_last only on the 8th; busy falls the cycle after.
- BUF_DEPTH=4, out_ready=0 -> exactly 4 commands issued, then cmd_valid=0. Raise out_ready -> issuing resumes, with one command per popped word.
- Offset 0x1FFFFFE, FRAME_WORDS=4 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
- start_frame pulsed during FETCH -> ignored; addresses continue from the original offset; frame completes normally.
- rd_valid while in IDLE -> err=1 and out_valid stays 0. With the macro defined, a return with the wrong rd_addr mid-frame -> err=1 and the frame still completes with 8 words.
- rst asserted mid-FETCH after the controller is quiesced -> next cycle state IDLE and all outputs 0. A new start_frame then runs a clean frame with err=0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM-side types and widths for the frame reader and its helpers.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fr_state_t;

  // Width able to hold any value 0..depth for a power-of-two depth.
  function automatic int credit_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdram_frame_reader_if.sv
// Bus bundle for sdram_frame_reader: frame control, arbiter command, read return
// and pixel output. The master modport is the reader's view.
interface sdram_frame_reader_if;
  import sdram_pkg::*;

  logic                    start_frame;
  logic [SDRAM_ADDR_W-1:0] frame_offset;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [SDRAM_ADDR_W-1:0] cmd_addr;
  logic                    urgent;
  logic                    rd_valid;
  logic [SDRAM_ADDR_W-1:0] rd_addr;
  logic [SDRAM_DATA_W-1:0] rd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SDRAM_DATA_W-1:0] out_data;
  logic                    out_last;
  logic                    busy;
  logic                    err;

  modport master (
    input  start_frame, frame_offset, cmd_ready, rd_valid, rd_addr, rd_data, out_ready,
    output cmd_valid, cmd_addr, urgent, out_valid, out_data, out_last, busy, err
  );

  modport slave (
    output start_frame, frame_offset, cmd_ready, rd_valid, rd_addr, rd_data, out_ready,
    input  cmd_valid, cmd_addr, urgent, out_valid, out_data, out_last, busy, err
  );

endinterface

// File: rtl/sdram_frame_reader_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output; DEPTH must be
// a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && (count_q != FULL_C);
  assign do_rd = rd_en && (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{PTR_W{1'b0}}, do_wr} - {{PTR_W{1'b0}}, do_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Head word is shown directly; forced to zero while empty so out_data idles at 0.
  assign valid   = (count_q != '0);
  assign rd_data = valid ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/sdram_frame_reader.sv
// Credit-controlled SDRAM frame read feeder: issues sequential reads, buffers
// in-order returns and streams pixels. Optional macro SDRAM_FRAME_READER_ADDR_CHECK_EN.
module sdram_frame_reader
  import sdram_pkg::*;
#(
  parameter int FRAME_WORDS = 307200,
  parameter int BUF_DEPTH   = 64,
  parameter int LOW_WATER   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_frame_reader_if.master bus
);

  localparam int FW_W = $clog2(FRAME_WORDS + 1);
  localparam int CR_W = credit_w(BUF_DEPTH);
  localparam logic [FW_W-1:0] LAST_WORD = FW_W'(FRAME_WORDS - 1);
  localparam logic [CR_W-1:0] DEPTH_C   = CR_W'(BUF_DEPTH);
  localparam logic [CR_W-1:0] LOW_C     = CR_W'(LOW_WATER);

  fr_state_t               state_q;
  logic [FW_W-1:0]         issued_q, returned_q, popped_q;
  logic [FW_W-1:0]         issued_d, returned_d, popped_d;
  logic [SDRAM_ADDR_W-1:0] offset_q, offset_d, cmd_addr_q;
  logic                    cmd_valid_q, urgent_q, busy_q, err_q;
  logic [CR_W-1:0]         inflight, inflight_d, buffered_d, credit_d, fifo_count;
  logic                    start_acc, issue, push, pop, spurious, addr_bad;
  logic                    fifo_valid;
  logic [SDRAM_DATA_W-1:0] fifo_data;

  assign inflight = CR_W'(issued_q - returned_q);

  always_comb begin
    start_acc  = (state_q == IDLE) && bus.start_frame;
    issue      = cmd_valid_q && bus.cmd_ready;
    push       = bus.rd_valid && (inflight != '0);
    spurious   = bus.rd_valid && (inflight == '0);
    pop        = fifo_valid && bus.out_ready;
    issued_d   = start_acc ? '0 : issued_q   + FW_W'(issue);
    returned_d = start_acc ? '0 : returned_q + FW_W'(push);
    popped_d   = start_acc ? '0 : popped_q   + FW_W'(pop);
    offset_d   = start_acc ? bus.frame_offset : offset_q;
    // Registered request flags are derived from next-cycle counts so they equal
    // the credit rule evaluated on the counters they are presented alongside.
    inflight_d = CR_W'(issued_d - returned_d);
    buffered_d = fifo_count + CR_W'(push) - CR_W'(pop);
    credit_d   = inflight_d + buffered_d;
  end

`ifdef SDRAM_FRAME_READER_ADDR_CHECK_EN
  logic [SDRAM_ADDR_W-1:0] exp_addr;
  assign exp_addr = offset_q + SDRAM_ADDR_W'(returned_q);
  assign addr_bad = push && (bus.rd_addr != exp_addr);
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^bus.rd_addr;
  assign addr_bad       = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (SDRAM_DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (bus.rd_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      returned_q  <= '0;
      popped_q    <= '0;
      offset_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_valid_q <= 1'b0;
      urgent_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      popped_q    <= popped_d;
      offset_q    <= offset_d;
      cmd_addr_q  <= offset_d + SDRAM_ADDR_W'(issued_d);
      cmd_valid_q <= 1'b0;
      urgent_q    <= 1'b0;
      if (spurious || addr_bad) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            state_q     <= FETCH;
            busy_q      <= 1'b1;
            cmd_valid_q <= (credit_d < DEPTH_C);
            urgent_q    <= (credit_d < LOW_C);
          end
        end
        FETCH: begin
          if (issue && (issued_q == LAST_WORD)) begin
            state_q <= DRAIN;
          end else begin
            cmd_valid_q <= (credit_d < DEPTH_C);
            urgent_q    <= (credit_d < LOW_C);
          end
        end
        DRAIN: begin
          if (pop && (popped_q == LAST_WORD)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.urgent    = urgent_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_data;
  assign bus.out_last  = fifo_valid && (popped_q == LAST_WORD);

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Scoreboard bench for sdram_frame_reader: a frame-level model predicts commands,
// flags and pixel words; the SDRAM controller is modelled with an in-order return queue.
module tb_sdram_frame_reader;
  import sdram_pkg::*;

  localparam int FW = 8;
  localparam int BD = 4;
  localparam int LW = 2;

  typedef struct { logic [24:0] addr; int due; } pend_t;
  typedef struct { logic [15:0] data; logic last; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_frame_reader_if bus();

  sdram_frame_reader #(
    .FRAME_WORDS (FW),
    .BUF_DEPTH   (BD),
    .LOW_WATER   (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          issued_cnt = 0;
  int          ret_cnt = 0;
  int          pop_cnt = 0;
  int          words_in_buf = 0;
  int          ret_delay = 1;
  bit          model_active = 0;
  bit          exp_err = 0;
  bit          rand_mode = 0;
  bit          corrupt_req = 0;
  bit          inject_req = 0;
  logic [24:0] model_offset = '0;
  pend_t       pending[$];
  exp_t        exp_out[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SDRAM controller model: random ready/backpressure and in-order returns.
  initial begin
    pend_t p;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rand_mode) begin
        bus.cmd_ready = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      bus.rd_valid = 1'b0;
      if (inject_req) begin
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 25'($urandom);
        bus.rd_data  = 16'($urandom);
        inject_req   = 0;
      end else if (pending.size() != 0 && pending[0].due <= cyc) begin
        p = pending.pop_front();
        bus.rd_valid = 1'b1;
        bus.rd_addr  = corrupt_req ? (p.addr ^ 25'h1) : p.addr;
        bus.rd_data  = 16'($urandom);
        corrupt_req  = 0;
      end
    end
  end

  // Monitor: per-cycle flag checks, then scoreboard updates for this cycle's handshakes.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [24:0] a;
    bit          fetching;
    if (!rst) begin
      fetching = model_active && (issued_cnt < FW);
      check("cmd_valid", bus.cmd_valid, fetching && (issued_cnt - pop_cnt < BD));
      check("urgent", bus.urgent, fetching && (issued_cnt - pop_cnt < LW));
      check("busy", bus.busy, model_active);
      check("out_valid", bus.out_valid, words_in_buf > 0);
      check("err", bus.err, exp_err);
      if (bus.rd_valid) begin
        if (issued_cnt - ret_cnt > 0) begin
`ifdef SDRAM_FRAME_READER_ADDR_CHECK_EN
          a = model_offset + 25'(ret_cnt);
          if (bus.rd_addr != a) exp_err = 1;
`endif
          e.data = bus.rd_data;
          e.last = (ret_cnt == FW - 1);
          exp_out.push_back(e);
          ret_cnt++;
          words_in_buf++;
        end else begin
          exp_err = 1;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        a = model_offset + 25'(issued_cnt);
        check("cmd_addr", bus.cmd_addr, a);
        pending.push_back('{addr: a,
                            due: cyc + 1 + (rand_mode ? int'($urandom_range(0, 3)) : ret_delay)});
        issued_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) begin
          check("out_unexpected", bus.out_data, 32'hDEAD_0000);
        end else begin
          e = exp_out.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_last", bus.out_last, e.last);
        end
        words_in_buf--;
        pop_cnt++;
        if (pop_cnt == FW) model_active = 0;
      end
    end
  end

  task automatic start(input logic [24:0] off);
    @(posedge clk);
    #1;
    bus.start_frame  = 1'b1;
    bus.frame_offset = off;
    @(posedge clk);
    #1;
    bus.start_frame = 1'b0;
    model_offset = off;
    issued_cnt   = 0;
    ret_cnt      = 0;
    pop_cnt      = 0;
    model_active = 1;
    $display("[TB] frame start offset=0x%07h", off);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (model_active && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, model_active, 0);
    @(negedge clk);
    $display("[TB] frame done (%s) after %0d cycles", name, n);
  endtask

  task automatic wait_issued(input int cnt, input string name);
    for (int n = 0; n < 500 && !(issued_cnt >= cnt && pending.size() == 0); n++)
      @(negedge clk);
    check(name, (issued_cnt >= cnt) && (pending.size() == 0), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"}, bus.cmd_valid, 0);
    check({tag, "_urgent"}, bus.urgent, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_cmd_addr"}, bus.cmd_addr, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
  endtask

  initial begin
    bus.start_frame  = 1'b0;
    bus.frame_offset = '0;
    bus.cmd_ready    = 1'b0;
    bus.rd_valid     = 1'b0;
    bus.rd_addr      = '0;
    bus.rd_data      = '0;
    bus.out_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    bus.cmd_ready = 1'b1;
    bus.out_ready = 1'b1;
    start(25'h100);
    wait_done("basic");

    bus.out_ready = 1'b0;
    start(25'h2000);
    repeat (20) @(negedge clk);
    check("bp_issued", issued_cnt, BD);
    check("bp_cmd_valid", bus.cmd_valid, 0);
    bus.out_ready = 1'b1;
    wait_done("backpressure");

    start(25'h1FFFFFE);
    wait_done("wrap");

    start(25'h300);
    repeat (2) @(posedge clk);
    #1;
    bus.start_frame  = 1'b1;
    bus.frame_offset = 25'h5000;
    @(posedge clk);
    #1 bus.start_frame = 1'b0;
    wait_done("restart_ignored");
    check("restart_err", bus.err, 0);

    start(25'h400);
    wait_issued(3, "corrupt_wait");
    corrupt_req = 1;
    wait_done("addr_corrupt");
`ifdef SDRAM_FRAME_READER_ADDR_CHECK_EN
    check("addr_err", bus.err, 1);
`else
    check("addr_err", bus.err, 0);
`endif

    @(posedge clk);
    #1 inject_req = 1;
    repeat (4) @(negedge clk);
    check("spurious_err", bus.err, 1);
    check("spurious_out_valid", bus.out_valid, 0);

    bus.out_ready = 1'b0;
    start(25'h600);
    wait_issued(BD, "quiesce");
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    model_active = 0;
    exp_err      = 0;
    issued_cnt   = 0;
    ret_cnt      = 0;
    pop_cnt      = 0;
    words_in_buf = 0;
    exp_out.delete();
    pending.delete();
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    bus.out_ready = 1'b1;
    start(25'h700);
    wait_done("post_reset");
    check("post_reset_err", bus.err, 0);

    rand_mode = 1;
    for (int i = 0; i < 8; i++) begin
      logic [24:0] off;
      off = (i % 2 == 1) ? 25'h1FFFFFF - 25'($urandom_range(0, 8)) : 25'($urandom);
      start(off);
      wait_done("random");
    end
    rand_mode = 0;
    check("final_err", bus.err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
